otter_fetch_buffer: RTL and testbench

- Instruction-fetch stage sitting directly upstream of decode and the immediate generator.
- Holds the PC, issues word reads to instruction memory (fixed 1-cycle read latency), and buffers returned instructions with their PCs in a small FIFO.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- Redirects on FLUSH (branch/jump/trap) and discards stale in-flight data.

---
 rtl/otter_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/otter_fetch_buffer.sv | 116 +++++++++++
 tb/tb_otter_fetch_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the otter instruction-fetch stage.
// Holds the fetch FIFO entry layout and the fetch constants.
package otter_fetch_pkg;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetched instructions with their PCs.
// Synchronous clear has priority over push and pop.
module fetch_fifo
  import otter_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Entry storage: write the tail slot on an accepted push
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/otter_fetch_buffer.sv
// Fetch stage: PC, 1-cycle imem requests, credit-limited FIFO to decode.
// Optional macro FETCH_STALL_CNT_EN adds a saturating STALL_CNT output.
module otter_fetch_buffer
  import otter_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_PC,
  output logic        IMEM_RD_EN,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DOUT,
  output logic        INS_VALID,
  output logic [31:0] INS,
  output logic [31:0] INS_PC,
  input  logic        INS_READY
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] STALL_CNT
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [31:0]   pend_pc;
  logic [31:0]   last_pc;
  logic          pend;
  logic          drop;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [CW:0]   used;
  logic [CW:0]   limit;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;

  // A pop this cycle frees a slot, so it counts as credit for a new request
  assign pop        = INS_VALID && INS_READY && !FLUSH;
  assign push       = pend && !drop && !FLUSH;
  assign wr_entry   = '{pc: pend_pc, ins: IMEM_DOUT};
  assign used       = {1'b0, count} + (CW+1)'(pend);
  assign limit      = (CW+1)'(DEPTH) + (CW+1)'(pop);
  assign IMEM_RD_EN = RST_N && !FLUSH && (used < limit);
  assign IMEM_ADDR  = pc;
  assign INS_VALID  = !empty;
  assign INS        = empty ? INSN_NOP : head.ins;
  assign INS_PC     = empty ? last_pc : head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (FLUSH),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // PC, in-flight request tracking and stale-response drop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
      drop    <= 1'b0;
    end else if (FLUSH) begin
      pc   <= FLUSH_PC & ~32'h3;
      pend <= 1'b0;
      drop <= pend;
    end else begin
      pend <= IMEM_RD_EN;
      drop <= 1'b0;
      if (IMEM_RD_EN) begin
        pc      <= pc + PC_INC;
        pend_pc <= pc;
      end
    end
  end

  // Remember the last presented PC so INS_PC holds while empty
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_pc <= '0;
    end else if (!empty) begin
      last_pc <= head.pc;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Count cycles with nothing to offer decode, saturating
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STALL_CNT <= '0;
    end else if (!INS_VALID && !FLUSH && (STALL_CNT != '1)) begin
      STALL_CNT <= STALL_CNT + 32'd1;
    end
  end
`endif

  ap_no_overflow: assert property (
    @(posedge CLK) disable iff (!RST_N)
    !(push && full && !pop)
  );

endmodule

// File: tb/tb_otter_fetch_buffer.sv
// Randomized bench for otter_fetch_buffer with a queue-based reference.
// Memory returns addr ^ 32'hA5A5_0000 one cycle after each request.
module tb_otter_fetch_buffer;
  import otter_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] FLUSH_PC = '0;
  logic        IMEM_RD_EN;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DOUT = '0;
  logic        INS_VALID;
  logic [31:0] INS;
  logic [31:0] INS_PC;
  logic        INS_READY = 1'b0;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] STALL_CNT;
`endif

  int          errs = 0;
  int          checks = 0;
  int          now = 0;
  int          reqs = 0;
  int          q[$];
  logic [31:0] m_req;
  logic [31:0] m_acc;
  logic [31:0] m_last;
  logic [31:0] m_stall;
  bit          last_en;
  logic [31:0] last_addr;

  always #5 CLK = ~CLK;

  otter_fetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .FLUSH      (FLUSH),
    .FLUSH_PC   (FLUSH_PC),
    .IMEM_RD_EN (IMEM_RD_EN),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_DOUT  (IMEM_DOUT),
    .INS_VALID  (INS_VALID),
    .INS        (INS),
    .INS_PC     (INS_PC),
    .INS_READY  (INS_READY)
`ifdef FETCH_STALL_CNT_EN
    ,
    .STALL_CNT  (STALL_CNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req   = 32'h0;
    m_acc   = 32'h0;
    m_last  = 32'h0;
    m_stall = 32'h0;
    last_en = 1'b0;
  endtask

  // One clock cycle: drive inputs, check at negedge, answer memory
  task automatic cyc(input bit fl, input logic [31:0] fpc, input bit rdy);
    bit ev;
    bit acc;
    bit exp_rd;
    FLUSH     = fl;
    FLUSH_PC  = fpc;
    INS_READY = rdy;
    @(negedge CLK);
    ev = (q.size() > 0) && (q[0] + 2 <= now);
    chk("valid", INS_VALID, ev);
    if (ev) begin
      chk("ins_pc", INS_PC, m_acc);
      chk("ins", INS, m_acc ^ K);
    end else begin
      chk("nop", INS, INSN_NOP);
      chk("pc_hold", INS_PC, m_last);
    end
    acc    = ev && rdy && !fl;
    exp_rd = !fl && ((q.size() - int'(acc)) < DEPTH);
    chk("rd_en", IMEM_RD_EN, exp_rd);
    if (exp_rd) chk("addr", IMEM_ADDR, m_req);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", STALL_CNT, m_stall);
`endif
    if (ev) m_last = m_acc;
    if (!ev && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (fl) begin
      q.delete();
      m_req = fpc & ~32'h3;
      m_acc = fpc & ~32'h3;
    end else begin
      if (acc) begin
        void'(q.pop_front());
        m_acc += 32'd4;
      end
      if (exp_rd) begin
        q.push_back(now);
        m_req += 32'd4;
        reqs++;
      end
    end
    last_en   = IMEM_RD_EN;
    last_addr = IMEM_ADDR;
    now++;
    @(posedge CLK);
    #1;
    IMEM_DOUT = last_en ? (last_addr ^ K) : $urandom;
  endtask

  // Asynchronous reset mid-cycle, released at the start of a cycle
  task automatic do_reset();
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_valid", INS_VALID, 1'b0);
    chk("async_ins", INS, INSN_NOP);
    chk("async_rd_en", IMEM_RD_EN, 1'b0);
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    IMEM_DOUT = $urandom;
  endtask

  initial begin
    bit          fl;
    bit          rdy;
    logic [31:0] fpc;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", INS_VALID, 1'b0);
    chk("rst_ins", INS, INSN_NOP);
    chk("rst_ins_pc", INS_PC, 32'h0);
    chk("rst_rd_en", IMEM_RD_EN, 1'b0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Streaming with decode always ready
    repeat (10) cyc(1'b0, 32'h0, 1'b1);

    // Decode stalled right after reset: only DEPTH requests
    do_reset();
    reqs = 0;
    repeat (10) cyc(1'b0, 32'h0, 1'b0);
    chk("stalled_reqs", reqs, DEPTH);
    repeat (6) cyc(1'b0, 32'h0, 1'b1);

    // Flush with a response in flight, unaligned target
    cyc(1'b1, 32'h0000_0102, 1'b1);
    repeat (6) cyc(1'b0, 32'h0, 1'b1);

    // Back-to-back flushes, last target wins
    cyc(1'b1, 32'h0000_0200, 1'b1);
    cyc(1'b1, 32'h0000_0300, 1'b1);
    repeat (6) cyc(1'b0, 32'h0, 1'b1);

    // PC wrap at the top of the address space
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (5) cyc(1'b0, 32'h0, 1'b1);

    // Mid-stream reset, then restart
    do_reset();
    repeat (6) cyc(1'b0, 32'h0, 1'b1);

    // Random traffic
    repeat (400) begin
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      fpc = $urandom;
      if ($urandom_range(0, 3) == 0) fpc = 32'hFFFF_FFF4 | ($urandom & 32'h3);
      cyc(fl, fpc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
